// File: rtl/delay_scheduler_if.sv
// Request/grant bundle between the game FSMs (master) and the shared delay timer (slave).
interface delay_scheduler_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned DUR_W = 12
);
  logic [N_REQ-1:0]       i_Req;
  logic [N_REQ*DUR_W-1:0] i_Dur;
  logic                   i_Abort;
  logic [N_REQ-1:0]       o_Grant;
  logic [N_REQ-1:0]       o_Done;
  logic                   o_Busy;
  logic [DUR_W-1:0]       o_Remaining;
  logic                   o_Tick;

  modport master (
    output i_Req, i_Dur, i_Abort,
    input  o_Grant, o_Done, o_Busy, o_Remaining, o_Tick
  );

  modport slave (
    input  i_Req, i_Dur, i_Abort,
    output o_Grant, o_Done, o_Busy, o_Remaining, o_Tick
  );
endinterface

// File: rtl/delay_scheduler.sv
// Round-robin shared millisecond delay timer: grants one requester at a time,
// counts its duration down in TICK_DIV-cycle ticks and pulses done at expiry.
module delay_scheduler #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DUR_W    = 12
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  delay_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] win_q;
  logic [PRE_W-1:0] pre_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;
  logic             tick_q;
  logic [DUR_W-1:0] rem_q;

  logic [IDX_W-1:0] win_d;
  logic             win_found_c;
  logic [IDX_W-1:0] ptr_d;
  logic [PRE_W-1:0] pre_d;
  logic             cancel_c;

  // Round-robin arbiter: first asserted request at or above the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    win_d       = '0;
    win_found_c = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found_c && bus.i_Req[IDX_W'(idx)]) begin
        win_found_c = 1'b1;
        win_d       = IDX_W'(idx);
      end
    end
  end

  assign ptr_d    = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
  assign pre_d    = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
  assign cancel_c = bus.i_Abort | ~bus.i_Req[win_q];

  // Tick and decrement are registered one cycle ahead so they appear together
  // with the prescaler reaching its last count.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      pre_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      tick_q <= 1'b0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found_c && !bus.i_Abort) begin
            win_q   <= win_d;
            rem_q   <= bus.i_Dur[32'(win_d)*DUR_W +: DUR_W];
            grant_q <= N_REQ'(1) << win_d;
            busy_q  <= 1'b1;
            pre_q   <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cancel_c) begin
            state_q <= S_IDLE;
            ptr_q   <= ptr_d;
            grant_q <= '0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            pre_q   <= '0;
          end else if (rem_q == '0) begin
            state_q <= S_DONE;
            done_q  <= grant_q;
          end else begin
            state_q <= S_RUN;
            pre_q   <= '0;
            if (PRE_LAST == '0) begin
              tick_q <= 1'b1;
              rem_q  <= rem_q - DUR_W'(1);
            end
          end
        end
        S_RUN: begin
          if (cancel_c) begin
            state_q <= S_IDLE;
            ptr_q   <= ptr_d;
            grant_q <= '0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            pre_q   <= '0;
          end else if (pre_q == PRE_LAST && rem_q == '0) begin
            state_q <= S_DONE;
            done_q  <= grant_q;
          end else begin
            pre_q <= pre_d;
            if (pre_d == PRE_LAST && rem_q != '0) begin
              tick_q <= 1'b1;
              rem_q  <= rem_q - DUR_W'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ptr_q   <= ptr_d;
          grant_q <= '0;
          busy_q  <= 1'b0;
          rem_q   <= '0;
          pre_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_Grant     = grant_q;
  assign bus.o_Done      = done_q;
  assign bus.o_Busy      = busy_q;
  assign bus.o_Remaining = rem_q;
  assign bus.o_Tick      = tick_q;

endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Shares one millisecond-resolution delay timer among several game-control requesters (deal pacing, dealer draw pause, result display hold). Each requester raises a request with a duration; the block grants the timer round-robin, counts the duration down in 1 ms ticks derived from clk_50M, and returns a one-cycle done pulse to the winner. It sits between the BlackJack game FSMs and the timing datapath, so each FSM waits on a done pulse and does not run its own counter.

## Interface
- N_REQ, default 3: number of requesters.
- TICK_DIV, default 50000: clk_50M cycles per tick (1 ms at 50 MHz).
- DUR_W, default 12: duration width in ticks (max 4095 ms).

- clk_50M  in  1  system clock, 50 MHz.
- i_Reset  in  1  reset, synchronous, active-high; clock clk_50M.
- i_Req  in  N_REQ  per-requester request level.
- i_Dur  in  N_REQ*DUR_W  durations; requester k uses bits [k*DUR_W +: DUR_W].
- i_Abort  in  1  cancels the active delay; no done pulse.
- o_Grant  out  N_REQ  one-hot owner of the timer; all-zero when idle.
- o_Done  out  N_REQ  one-cycle pulse to the owner at expiry.
- o_Busy  out  1  high in LOAD, RUN and DONE.
- o_Remaining  out  DUR_W  ticks left in the active delay.
- o_Tick  out  1  one-cycle pulse at each tick boundary while in RUN.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- Reset: state IDLE, round-robin pointer 0, prescaler 0, every output 0. Reset in any state stops the delay immediately and emits no done pulse.
- IDLE:
  - Winner is the first asserted i_Req found scanning from the pointer upward, wrapping modulo N_REQ.
  - Latch the winner index and its i_Dur slice, then go to LOAD.
  - With no request, or with i_Abort high, stay in IDLE.
- LOAD:
  - o_Grant is one-hot at the winner and o_Remaining holds the latched duration. Prescaler clears to 0.
  - Duration 0 goes to DONE; otherwise go to RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At TICK_DIV-1: o_Tick pulses and o_Remaining decrements.
  - The decrement 1→0 goes to DONE.
- DONE:
  - o_Done[winner] is high for exactly this cycle, with o_Grant still asserted.
  - Pointer becomes (winner+1) mod N_REQ. Go to IDLE.
- Cancel: in LOAD or RUN, if i_Abort is high or i_Req[winner] drops, the next state is IDLE.
  - No done pulse; pointer advances as in DONE.
  - Abort takes priority over a simultaneous final tick.
- Requesters must hold i_Req and i_Dur stable until done. i_Dur changes after the IDLE sample are ignored.
- A request still high in the IDLE cycle after DONE counts as a new request. Round-robin order gives every other pending requester priority first.
- Width: o_Remaining never underflows. It is 0 in IDLE and after cancel or done.

## Timing
- Request seen in IDLE at cycle 0 → o_Grant and o_Busy at cycle 1 (LOAD) → RUN from cycle 2.
- Duration D≥1: o_Tick at cycles 1+k*TICK_DIV for k=1..D. o_Done at cycle 2+D*TICK_DIV.
- Duration 0: o_Done at cycle 2.
- Back-to-back: the earliest next grant is 2 cycles after the done pulse (IDLE, then LOAD).
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
(Simulate with TICK_DIV=4, DUR_W=12.)
- Single request: i_Req=001, D=3 from cycle 0 → o_Grant=001 from cycle 1. o_Tick at cycles 5, 9, 13. o_Remaining goes 3,2,1,0. o_Done=001 at cycle 14 only. o_Busy low at cycle 15.
- Zero duration: i_Req=010, D=0 → o_Grant=010 at cycle 1. o_Done=010 at cycle 2. No o_Tick.
- Round-robin: i_Req=111 held, each D=1, each requester drops its request after its done → grants in order 001, 010, 100. Pointer returns to 0. Restarting requester 0 keeps the order.
- Fairness with a held requester: i_Req=011 held, requester 0 re-raises immediately after its done → requester 1 is granted before requester 0's second grant.
- Cancel: D=5, drop i_Req[winner] at cycle 7 → IDLE at cycle 8 with o_Grant=0 and o_Remaining=0. No o_Done. The pointer has advanced.
- Reset and abort: i_Reset high mid-RUN → next cycle all outputs 0 and state IDLE. i_Abort coinciding with the final tick → no o_Done.
